// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot loader block.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN
  } loader_state_t;

  // Byte stride between consecutive 32-bit words in memory.
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_port_mux.sv
// Memory port selector: the loader owns the port until the processor is
// released, after which processor traffic passes straight through.
module mem_port_mux (
  input  logic        sel_cpu,
  input  logic [31:0] ld_adr,
  input  logic [31:0] ld_writedata,
  input  logic        ld_memwrite,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_writedata,
  input  logic        cpu_memwrite,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writedata,
  output logic        mem_memwrite
);

  // Pure combinational select, zero latency in either direction.
  assign mem_adr       = sel_cpu ? cpu_adr       : ld_adr;
  assign mem_writedata = sel_cpu ? cpu_writedata : ld_writedata;
  assign mem_memwrite  = sel_cpu ? cpu_memwrite  : ld_memwrite;

endmodule

// File: rtl/mem_loader.sv
// Boot loader: holds the processor in reset, streams WORDS program words
// into memory from a valid/ready source, then releases the processor and
// hands the memory port over to it.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int          WORDS    = 64,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int          CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_writedata,
  input  logic        cpu_memwrite,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writedata,
  output logic        mem_memwrite,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  loader_state_t    state;
  logic [CNT_W-1:0] count;
  logic             cpu_reset_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic [31:0]      ld_adr;
  logic [31:0]      ld_writedata;
  logic             sel_cpu;

  // Handshake: load_start takes priority over any word in the same cycle.
  // Gating with reset keeps a reset cycle from writing a stray word.
  assign in_ready = (state == LOAD) && !load_start && reset;
  assign accept   = in_ready && in_valid;

  // Loader side of the memory port; outside LOAD it is parked at zero.
  assign ld_adr       = (state == LOAD) ? BASE_ADR + 32'(count) * 32'(WORD_BYTES) : '0;
  assign ld_writedata = accept ? in_data : '0;

  // Processor owns the port in RUN unless a restart is being requested.
  assign sel_cpu = (state == RUN) && !load_start;

  // A restart must reach the processor in the same cycle it is requested.
  assign cpu_reset = cpu_reset_q || load_start;
  assign busy      = busy_q;
  assign done      = done_q;

  mem_port_mux u_mux (
    .sel_cpu       (sel_cpu),
    .ld_adr        (ld_adr),
    .ld_writedata  (ld_writedata),
    .ld_memwrite   (accept),
    .cpu_adr       (cpu_adr),
    .cpu_writedata (cpu_writedata),
    .cpu_memwrite  (cpu_memwrite),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata),
    .mem_memwrite  (mem_memwrite)
  );

  // Loader FSM with word counter, running checksum and registered status.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // reset is synchronous, so it is only tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      checksum    <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (load_start) begin
      state       <= LOAD;
      count       <= '0;
      checksum    <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (accept) begin
            checksum <= checksum + in_data;
            if (count == LAST_IDX) begin
              state <= RELEASE;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          state       <= RUN;
          cpu_reset_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end
        RUN: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a vector table for the basic load,
// pass-through and restart, hand sequences for gaps, mid-load reset and the
// single-word configuration, and a randomized run against a reference model.
module tb_mem_loader;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: four words from address 0.
  logic        a_rst, a_ls, a_valid, a_cpu_we;
  logic [31:0] a_data, a_cpu_adr, a_cpu_wd;
  logic        a_ready, a_we, a_cpu_reset, a_busy, a_done;
  logic [31:0] a_adr, a_wd, a_cs;

  // Instance B: one word at 0x100.
  logic        b_rst, b_ls, b_valid, b_cpu_we;
  logic [31:0] b_data, b_cpu_adr, b_cpu_wd;
  logic        b_ready, b_we, b_cpu_reset, b_busy, b_done;
  logic [31:0] b_adr, b_wd, b_cs;

  mem_loader #(.WORDS(4), .BASE_ADR(32'h0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(a_rst), .load_start(a_ls),
    .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .cpu_adr(a_cpu_adr), .cpu_writedata(a_cpu_wd), .cpu_memwrite(a_cpu_we),
    .mem_adr(a_adr), .mem_writedata(a_wd), .mem_memwrite(a_we),
    .cpu_reset(a_cpu_reset), .busy(a_busy), .done(a_done), .checksum(a_cs)
  );

  mem_loader #(.WORDS(1), .BASE_ADR(32'h100), .CNT_W(16)) dut_b (
    .clk(clk), .reset(b_rst), .load_start(b_ls),
    .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .cpu_adr(b_cpu_adr), .cpu_writedata(b_cpu_wd), .cpu_memwrite(b_cpu_we),
    .mem_adr(b_adr), .mem_writedata(b_wd), .mem_memwrite(b_we),
    .cpu_reset(b_cpu_reset), .busy(b_busy), .done(b_done), .checksum(b_cs)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ls;
    logic        valid;
    logic [31:0] data;
    logic [31:0] cadr;
    logic [31:0] cwd;
    logic        cwe;
    logic        chk_port;   // compare mem_adr/mem_writedata this row
    logic        ready;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [31:0] cs;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] w1[4];
  logic [31:0] w2[4];
  logic [31:0] sum4;

  // Reference model state (abstract: a load in progress with a word index,
  // a one-cycle release pending, or the processor running).
  bit          m_loading, m_pending, m_running;
  int          m_idx;
  logic [31:0] m_sum;

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rs, ls, v, cwe, acc, chk_port;
    logic [31:0] d, cadr, cwd, e_adr, e_wd, sum_new;
    logic        e_we, e_ready;

    w1[0] = 32'h20020005; w1[1] = 32'h2003000C;
    w1[2] = 32'h2067FFF7; w1[3] = 32'hAC070054;
    sum4 = w1[0] + w1[1] + w1[2] + w1[3];

    //          ls    vld   data   cadr   cwd    cwe  chk  rdy  we   adr    wd     crst busy done cs
    vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, w1[0], 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, w1[0], 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, w1[1], 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4, w1[1], 1'b1, 1'b1, 1'b0, w1[0]};
    vecs[3] = '{1'b0, 1'b1, w1[2], 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd8, w1[2], 1'b1, 1'b1, 1'b0, w1[0] + w1[1]};
    vecs[4] = '{1'b0, 1'b1, w1[3], 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd12, w1[3], 1'b1, 1'b1, 1'b0, w1[0] + w1[1] + w1[2]};
    vecs[5] = '{1'b0, 1'b1, 32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, sum4};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 32'd84, 32'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 1'b1, sum4};
    vecs[7] = '{1'b1, 1'b1, 32'h9, 32'd84, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, sum4};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 32'd84, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};

    a_rst = 1'b0; a_ls = 1'b0; a_valid = 1'b0; a_data = '0;
    a_cpu_adr = '0; a_cpu_wd = '0; a_cpu_we = 1'b0;
    b_rst = 1'b0; b_ls = 1'b0; b_valid = 1'b0; b_data = '0;
    b_cpu_adr = '0; b_cpu_wd = '0; b_cpu_we = 1'b0;
    step();
    step();
    a_rst = 1'b1;

    // Basic load, pass-through and restart from RUN, one row per cycle.
    for (int i = 0; i < 9; i++) begin
      a_ls = vecs[i].ls; a_valid = vecs[i].valid; a_data = vecs[i].data;
      a_cpu_adr = vecs[i].cadr; a_cpu_wd = vecs[i].cwd; a_cpu_we = vecs[i].cwe;
      #1;
      check1($sformatf("vec%0d in_ready", i), a_ready, vecs[i].ready);
      check1($sformatf("vec%0d mem_memwrite", i), a_we, vecs[i].we);
      if (vecs[i].chk_port) begin
        check($sformatf("vec%0d mem_adr", i), a_adr, vecs[i].adr);
        check($sformatf("vec%0d mem_writedata", i), a_wd, vecs[i].wd);
      end
      check1($sformatf("vec%0d cpu_reset", i), a_cpu_reset, vecs[i].cpu_reset);
      check1($sformatf("vec%0d busy", i), a_busy, vecs[i].busy);
      check1($sformatf("vec%0d done", i), a_done, vecs[i].done);
      check($sformatf("vec%0d checksum", i), a_cs, vecs[i].cs);
      step();
    end
    a_cpu_we = 1'b0; a_cpu_adr = '0; a_cpu_wd = '0;

    // Back-pressure: three idle cycles before each word (already in LOAD).
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 3; g++) begin
        a_valid = 1'b0; a_data = 32'hFFFF_FFFF;
        #1;
        check1($sformatf("gap%0d_%0d no write", k, g), a_we, 1'b0);
        step();
      end
      a_valid = 1'b1; a_data = w1[k];
      #1;
      check1($sformatf("gap word%0d write", k), a_we, 1'b1);
      check($sformatf("gap word%0d adr", k), a_adr, 32'(k * 4));
      check($sformatf("gap word%0d data", k), a_wd, w1[k]);
      step();
    end
    a_valid = 1'b0;
    #1;
    check1("gap release done low", a_done, 1'b0);
    check1("gap release cpu_reset", a_cpu_reset, 1'b1);
    check1("gap release no write", a_we, 1'b0);
    step();
    check1("gap done rises", a_done, 1'b1);
    check1("gap cpu_reset low", a_cpu_reset, 1'b0);
    check("gap checksum", a_cs, sum4);

    // Reset in the middle of a load, then a fresh load of new words.
    w2[0] = 32'h1111_0001; w2[1] = 32'h8000_0002;
    w2[2] = 32'hFFFF_FFF0; w2[3] = 32'h0BAD_F00D;
    a_ls = 1'b1; step(); a_ls = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_valid = 1'b1; a_data = w1[k]; step();
    end
    a_valid = 1'b0; a_rst = 1'b0; step();
    a_rst = 1'b1;
    #1;
    check1("rst cpu_reset", a_cpu_reset, 1'b1);
    check1("rst busy", a_busy, 1'b0);
    check1("rst in_ready", a_ready, 1'b0);
    check("rst checksum", a_cs, 32'h0);
    a_ls = 1'b1; step(); a_ls = 1'b0;
    sum_new = '0;
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1; a_data = w2[k];
      #1;
      check($sformatf("reload word%0d adr", k), a_adr, 32'(k * 4));
      check1($sformatf("reload word%0d write", k), a_we, 1'b1);
      sum_new = sum_new + w2[k];
      step();
    end
    a_valid = 1'b0; step();
    check1("reload done", a_done, 1'b1);
    check("reload checksum", a_cs, sum_new);

    // Randomized traffic against the reference model.
    a_rst = 1'b0; step();
    m_loading = 0; m_pending = 0; m_running = 0; m_idx = 0; m_sum = '0;
    for (int c = 0; c < 1500; c++) begin
      rs   = ($urandom_range(0, 199) < 2);
      ls   = ($urandom_range(0, 99) < 3);
      v    = ($urandom_range(0, 99) < 60);
      d    = $urandom;
      cadr = $urandom;
      cwd  = $urandom;
      cwe  = $urandom_range(0, 1) == 1;
      a_rst = ~rs; a_ls = ls; a_valid = v; a_data = d;
      a_cpu_adr = cadr; a_cpu_wd = cwd; a_cpu_we = cwe;
      #1;
      e_ready = m_loading && !ls && !rs;
      acc     = e_ready && v;
      if (!rs) begin
        chk_port = 1'b1;
        if (m_running && !ls) begin
          e_we = cwe; e_adr = cadr; e_wd = cwd;
        end else if (m_loading) begin
          e_we = acc; e_adr = 32'(m_idx) * 32'd4; e_wd = acc ? d : 32'h0;
        end else begin
          e_we = 1'b0; e_adr = 32'h0; e_wd = 32'h0;
          chk_port = !m_pending && !m_running;
        end
        check1($sformatf("rnd%0d in_ready", c), a_ready, e_ready);
        check1($sformatf("rnd%0d mem_memwrite", c), a_we, e_we);
        if (chk_port) begin
          check($sformatf("rnd%0d mem_adr", c), a_adr, e_adr);
          check($sformatf("rnd%0d mem_writedata", c), a_wd, e_wd);
        end
        check1($sformatf("rnd%0d cpu_reset", c), a_cpu_reset, !m_running || ls);
        check1($sformatf("rnd%0d busy", c), a_busy, m_loading || m_pending);
        check1($sformatf("rnd%0d done", c), a_done, m_running);
        check($sformatf("rnd%0d checksum", c), a_cs, m_sum);
      end
      if (rs) begin
        m_loading = 0; m_pending = 0; m_running = 0; m_idx = 0; m_sum = '0;
      end else if (ls) begin
        m_loading = 1; m_pending = 0; m_running = 0; m_idx = 0; m_sum = '0;
      end else if (acc) begin
        m_sum = m_sum + d;
        m_idx++;
        if (m_idx == 4) begin
          m_loading = 0; m_pending = 1; m_idx = 0;
        end
      end else if (m_pending) begin
        m_pending = 0; m_running = 1;
      end
      step();
    end
    a_rst = 1'b1; a_ls = 1'b0; a_valid = 1'b0; a_cpu_we = 1'b0;

    // Single-word configuration at a non-zero base.
    b_rst = 1'b1; step();
    b_ls = 1'b1;
    #1;
    check1("one ls cpu_reset", b_cpu_reset, 1'b1);
    check1("one ls in_ready", b_ready, 1'b0);
    step();
    b_ls = 1'b0; b_valid = 1'b1; b_data = 32'hDEADBEEF;
    #1;
    check1("one in_ready", b_ready, 1'b1);
    check1("one write", b_we, 1'b1);
    check("one adr", b_adr, 32'h100);
    check("one data", b_wd, 32'hDEADBEEF);
    step();
    b_valid = 1'b0;
    #1;
    check1("one release busy", b_busy, 1'b1);
    check1("one release done", b_done, 1'b0);
    check1("one release cpu_reset", b_cpu_reset, 1'b1);
    check1("one release no write", b_we, 1'b0);
    step();
    check1("one run done", b_done, 1'b1);
    check1("one run cpu_reset", b_cpu_reset, 1'b0);
    check("one checksum", b_cs, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
